led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, number of LED outputs (legal: WIDTH >= 2).
REQ-002 Parameter DIV, default 25_000_000, clock cycles per pattern step (legal: DIV >= 1).
REQ-003 Port clk  input  1  sole clock, rising-edge active.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  run enable; 0 freezes the prescaler and the pattern.
REQ-006 Port mode  input  2  pattern select: 0 BLINK, 1 CHASE_L, 2 CHASE_R, 3 PINGPONG.
REQ-007 Port OUT  output  WIDTH  registered LED drive, bit 0 = rightmost LED.
REQ-008 Port step  output  1  registered one-cycle pulse, high in the cycle after each OUT update.

Function
REQ-009 Prescaler cnt SHALL be a $clog2(DIV)-bit counter (min 1 bit) that increments while en=1 and holds while en=0.
REQ-010 tick SHALL be high when en=1 and cnt==DIV-1; on the tick edge cnt wraps to 0, giving exactly one OUT update per DIV enabled cycles.
REQ-011 With DIV=1, tick SHALL be high in every enabled cycle.
REQ-012 BLINK on tick: OUT <= ~OUT.
REQ-013 CHASE_L on tick: if OUT==0, OUT <= 1 (bit 0); otherwise OUT <= rotate-left-by-1(OUT), so MSB wraps to bit 0.
REQ-014 CHASE_R on tick: if OUT==0, OUT <= MSB set only; otherwise OUT <= rotate-right-by-1(OUT), so bit 0 wraps to MSB.
REQ-015 PINGPONG on tick: if OUT is not one-hot, OUT <= 1 and dir <= UP; with dir UP, OUT[WIDTH-1]=1 -> shift right, dir <= DOWN, else shift left; with dir DOWN, OUT[0]=1 -> shift left, dir <= UP, else shift right.
REQ-016 mode SHALL be registered into mode_q every cycle regardless of en; a difference between mode and mode_q is a mode change.
REQ-017 On a mode change edge, OUT <= 0, cnt <= 0 and dir <= UP; this takes priority over a simultaneous tick, and step stays 0.
REQ-018 step SHALL be 1 exactly in the cycle after an edge on which tick updated OUT, and 0 otherwise.
REQ-019 en deasserted mid-count SHALL hold cnt, OUT and dir; reasserting SHALL resume counting from the held cnt.
REQ-020 All arithmetic is unsigned; cnt never exceeds DIV-1.

Reset
REQ-021 reset_n=0 SHALL asynchronously force OUT=0, cnt=0, step=0, dir=UP and mode_q=0 (BLINK).
REQ-022 Reset SHALL be sampled low at any time, including mid-count; the first tick after release occurs DIV enabled cycles later.

Configuration
REQ-023 Macro LED_PATTERN_GEN_PINGPONG_EN defined: mode 3 SHALL behave per REQ-015.
REQ-024 Macro absent: mode 3 SHALL behave identically to BLINK (REQ-012), and the dir register SHALL NOT be built.

Structure
REQ-025 Package led_pkg SHALL hold the mode encodings (BLINK=2'd0, CHASE_L=2'd1, CHASE_R=2'd2, PINGPONG=2'd3) and the dir encoding (UP=1'b0, DOWN=1'b1).
REQ-026 The prescaler SHALL be a sub-module led_tick_div (parameter DIV; ports clk, reset_n, en, clr, tick), with clr driven by the mode change.

Verification (WIDTH=8, DIV=4 unless stated)
REQ-027 Reset, then en=1 with mode=0 for 8 cycles -> OUT 00 then FF after 4 cycles, then 00 after 8 cycles; step pulses one cycle after each update.
REQ-028 mode=1, en=1 from reset -> OUT sequence 00,01,02,04,...,80,01 every 4 cycles, showing wrap from MSB to bit 0.
REQ-029 mode=3 with the macro defined -> OUT sequence 01,02,...,80,40,...,01,02; with the macro undefined -> OUT sequence 00,FF,00.
REQ-030 Run mode=2 until OUT=20, then switch to mode=0 on the same edge as a tick -> OUT=00 on the next cycle, no step pulse, and the next change (to FF) comes 4 cycles later.
REQ-031 Drop en to 0 for 10 cycles at cnt=2 -> OUT and step held constant; after en returns to 1, the next tick comes 2 cycles later.
REQ-032 Assert reset_n=0 mid-count with OUT=0x10 -> OUT=00 immediately, without waiting for a clk edge; with DIV=1, OUT updates on every enabled cycle.

Source files
------------

// File: rtl/led_pattern_gen_pkg.sv
// led_pkg: mode and direction encodings shared by the LED pattern generator
package led_pkg;

   typedef enum logic [1:0] {
      BLINK    = 2'd0,
      CHASE_L  = 2'd1,
      CHASE_R  = 2'd2,
      PINGPONG = 2'd3
   } mode_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/led_pattern_gen_tick_div.sv
// led_tick_div: prescaler emitting one tick per DIV enabled cycles, clearable
module led_tick_div #(
   parameter int DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = en && (cnt == W'(DIV - 1));

   // count enabled cycles, wrap on tick, restart on clear
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern sequencer; define LED_PATTERN_GEN_PINGPONG_EN to build the PINGPONG mode
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 25_000_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] OUT,
   output logic             step
);

   mode_t            mode_q;
   logic             chg;
   logic             tick;
   logic [WIDTH-1:0] nxt;

   assign chg = (mode != mode_q);

   led_tick_div #(.DIV(DIV)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .clr     (chg),
      .tick    (tick)
   );

`ifdef LED_PATTERN_GEN_PINGPONG_EN
   dir_t dir;
   dir_t dir_nxt;
   logic one_hot;

   assign one_hot = (OUT != '0) && ((OUT & (OUT - WIDTH'(1))) == '0);

   // next pattern and bounce direction for the current mode
   always_comb begin
      nxt     = ~OUT;
      dir_nxt = dir;
      case (mode_q)
         CHASE_L:  nxt = (OUT == '0) ? WIDTH'(1) : {OUT[WIDTH-2:0], OUT[WIDTH-1]};
         CHASE_R:  nxt = (OUT == '0) ? {1'b1, {(WIDTH-1){1'b0}}} : {OUT[0], OUT[WIDTH-1:1]};
         PINGPONG: begin
            if (!one_hot) begin
               nxt     = WIDTH'(1);
               dir_nxt = UP;
            end else if (dir == UP) begin
               nxt     = OUT[WIDTH-1] ? (OUT >> 1) : (OUT << 1);
               dir_nxt = OUT[WIDTH-1] ? DOWN : UP;
            end else begin
               nxt     = OUT[0] ? (OUT << 1) : (OUT >> 1);
               dir_nxt = OUT[0] ? UP : DOWN;
            end
         end
         default:  nxt = ~OUT;
      endcase
   end

   // bounce direction, reset to UP on mode change, advanced on tick
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         dir <= UP;
      else if (chg)
         dir <= UP;
      else if (tick)
         dir <= dir_nxt;
`else
   // next pattern for the current mode; mode 3 falls back to blinking
   always_comb begin
      nxt = ~OUT;
      case (mode_q)
         CHASE_L: nxt = (OUT == '0) ? WIDTH'(1) : {OUT[WIDTH-2:0], OUT[WIDTH-1]};
         CHASE_R: nxt = (OUT == '0) ? {1'b1, {(WIDTH-1){1'b0}}} : {OUT[0], OUT[WIDTH-1:1]};
         default: nxt = ~OUT;
      endcase
   end
`endif

   // mode tracking, pattern register and step pulse; mode change beats tick
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         mode_q <= BLINK;
         OUT    <= '0;
         step   <= 1'b0;
      end else begin
         mode_q <= mode_t'(mode);
         step   <= tick && !chg;
         if (chg)
            OUT <= '0;
         else if (tick)
            OUT <= nxt;
      end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed bench for led_pattern_gen (DIV=4 and DIV=1 instances)
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en;
   logic [1:0] mode;
   logic [7:0] out4, out1;
   logic       step4, step1;
   int         errors = 0;
   int         checks = 0;

   led_pattern_gen #(.WIDTH(8), .DIV(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .mode    (mode),
      .OUT     (out4),
      .step    (step4)
   );

   led_pattern_gen #(.WIDTH(8), .DIV(1)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .mode    (mode),
      .OUT     (out1),
      .step    (step1)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] pp [$];
      reset_n = 1'b0;
      en      = 1'b0;
      mode    = 2'd0;
      cyc(2);
      chk("rst_out", out4, 8'h00);
      chk("rst_step", {7'b0, step4}, 8'h00);
      // blink from reset
      reset_n = 1'b1;
      en      = 1'b1;
      cyc(3);
      chk("blink_pre", out4, 8'h00);
      chk("blink_pre_step", {7'b0, step4}, 8'h00);
      cyc(1);
      chk("blink_ff", out4, 8'hFF);
      chk("blink_ff_step", {7'b0, step4}, 8'h01);
      cyc(1);
      chk("blink_ff_hold", out4, 8'hFF);
      chk("blink_step_drop", {7'b0, step4}, 8'h00);
      cyc(3);
      chk("blink_00", out4, 8'h00);
      chk("blink_00_step", {7'b0, step4}, 8'h01);
      // chase left with wrap
      mode = 2'd1;
      cyc(1);
      chk("chl_clear", out4, 8'h00);
      chk("chl_clear_step", {7'b0, step4}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         cyc(4);
         chk($sformatf("chl_%0d", i), out4, 8'h01 << i);
      end
      cyc(4);
      chk("chl_wrap", out4, 8'h01);
      // mode 3
      mode = 2'd3;
      cyc(1);
      chk("m3_clear", out4, 8'h00);
`ifdef LED_PATTERN_GEN_PINGPONG_EN
      pp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
      pp = '{8'hFF, 8'h00};
`endif
      foreach (pp[i]) begin
         cyc(4);
         chk($sformatf("m3_%0d", i), out4, pp[i]);
      end
      // chase right, then mode change coinciding with a tick
      mode = 2'd2;
      cyc(1);
      chk("chr_clear", out4, 8'h00);
      cyc(4);
      chk("chr_80", out4, 8'h80);
      cyc(4);
      chk("chr_40", out4, 8'h40);
      cyc(4);
      chk("chr_20", out4, 8'h20);
      cyc(3);
      mode = 2'd0;
      cyc(1);
      chk("chg_tick_out", out4, 8'h00);
      chk("chg_tick_step", {7'b0, step4}, 8'h00);
      cyc(3);
      chk("chg_wait", out4, 8'h00);
      cyc(1);
      chk("chg_ff", out4, 8'hFF);
      chk("chg_ff_step", {7'b0, step4}, 8'h01);
      // enable hold at cnt=2
      cyc(2);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk($sformatf("hold_out_%0d", i), out4, 8'hFF);
         chk($sformatf("hold_step_%0d", i), {7'b0, step4}, 8'h00);
      end
      en = 1'b1;
      cyc(1);
      chk("resume_1", out4, 8'hFF);
      cyc(1);
      chk("resume_2", out4, 8'h00);
      chk("resume_2_step", {7'b0, step4}, 8'h01);
      // async reset mid-count with OUT=10
      mode = 2'd1;
      cyc(21);
      chk("pre_rst_10", out4, 8'h10);
      cyc(2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out", out4, 8'h00);
      chk("async_rst_step", {7'b0, step4}, 8'h00);
      chk("async_rst_out1", out1, 8'h00);
      mode = 2'd0;
      cyc(1);
      reset_n = 1'b1;
      cyc(1);
      chk("div1_ff", out1, 8'hFF);
      chk("div1_step", {7'b0, step1}, 8'h01);
      cyc(1);
      chk("div1_00", out1, 8'h00);
      cyc(1);
      chk("div1_ff2", out1, 8'hFF);
      chk("post_rst_pre", out4, 8'h00);
      cyc(1);
      chk("div1_002", out1, 8'h00);
      chk("post_rst_ff", out4, 8'hFF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
